// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - round-robin arbiter sharing one data-memory channel among per-thread LSUs
//
// Purpose: grants a single outstanding read or write at a time to one of
// NUM_CONSUMERS LSUs, forwards the captured address/data to memory and
// returns the completion (and read data) to the grantee only.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   consumer_read_valid/_address    per-LSU read requests (packed slices)
//   consumer_read_ready/_data       per-LSU read completion and returned data
//   consumer_write_valid/_address/_data  per-LSU write requests
//   consumer_write_ready            per-LSU write completion
//   mem_read_*                      memory read channel
//   mem_write_*                     memory write channel
//   busy                            high whenever the arbiter is not idle
//   grant_id                        current or most recent grantee
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  localparam int ID_BITS      = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                             mem_read_valid,
  output logic [ADDR_BITS-1:0]             mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [DATA_BITS-1:0]             mem_read_data,
  output logic                             mem_write_valid,
  output logic [ADDR_BITS-1:0]             mem_write_address,
  output logic [DATA_BITS-1:0]             mem_write_data,
  input  logic                             mem_write_ready,
  output logic                             busy,
  output logic [ID_BITS-1:0]               grant_id
);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELEASE} state_t;

  state_t                           state_q, state_d;
  logic [ID_BITS-1:0]               rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0]               grant_id_q, grant_id_d;
  logic                             grant_read_q, grant_read_d;
  logic                             busy_q, busy_d;
  logic                             mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]             mem_read_address_q, mem_read_address_d;
  logic                             mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]             mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]             mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_q, consumer_read_ready_d;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready_q, consumer_write_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_q, consumer_read_data_d;

  // Round-robin scan starting at rr_ptr; first requester wins, read before write.
  logic scan_found;
  logic scan_read;
  int   scan_win;
  int   scan_idx;

  always_comb begin
    scan_found = 1'b0;
    scan_read  = 1'b0;
    scan_win   = 0;
    scan_idx   = 0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_CONSUMERS;
      if (!scan_found && (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
        scan_found = 1'b1;
        scan_read  = consumer_read_valid[scan_idx];
        scan_win   = scan_idx;
      end
    end
  end

  // Valid of the request that was granted; release waits for it to fall so
  // the same request cannot be granted twice.
  logic granted_valid;
  assign granted_valid = grant_read_q ? consumer_read_valid[grant_id_q]
                                      : consumer_write_valid[grant_id_q];

  always_comb begin
    state_d                = state_q;
    rr_ptr_d               = rr_ptr_q;
    grant_id_d             = grant_id_q;
    grant_read_d           = grant_read_q;
    mem_read_valid_d       = mem_read_valid_q;
    mem_read_address_d     = mem_read_address_q;
    mem_write_valid_d      = mem_write_valid_q;
    mem_write_address_d    = mem_write_address_q;
    mem_write_data_d       = mem_write_data_q;
    consumer_read_ready_d  = consumer_read_ready_q;
    consumer_write_ready_d = consumer_write_ready_q;
    consumer_read_data_d   = consumer_read_data_q;

    case (state_q)
      IDLE: begin
        if (scan_found) begin
          grant_id_d   = scan_win[ID_BITS-1:0];
          grant_read_d = scan_read;
          if (scan_read) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = consumer_read_address[scan_win*ADDR_BITS +: ADDR_BITS];
            state_d            = READ_WAIT;
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = consumer_write_address[scan_win*ADDR_BITS +: ADDR_BITS];
            mem_write_data_d    = consumer_write_data[scan_win*DATA_BITS +: DATA_BITS];
            state_d             = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_d = 1'b0;
          consumer_read_data_d[int'(grant_id_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
          consumer_read_ready_d[grant_id_q] = 1'b1;
          state_d = RELEASE;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_d = 1'b0;
          consumer_write_ready_d[grant_id_q] = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!granted_valid) begin
          consumer_read_ready_d  = '0;
          consumer_write_ready_d = '0;
          rr_ptr_d = (grant_id_q == ID_BITS'(NUM_CONSUMERS - 1)) ? '0 : grant_id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q                <= IDLE;
      rr_ptr_q               <= '0;
      grant_id_q             <= '0;
      grant_read_q           <= 1'b0;
      busy_q                 <= 1'b0;
      mem_read_valid_q       <= 1'b0;
      mem_read_address_q     <= '0;
      mem_write_valid_q      <= 1'b0;
      mem_write_address_q    <= '0;
      mem_write_data_q       <= '0;
      consumer_read_ready_q  <= '0;
      consumer_write_ready_q <= '0;
      consumer_read_data_q   <= '0;
    end else begin
      state_q                <= state_d;
      rr_ptr_q               <= rr_ptr_d;
      grant_id_q             <= grant_id_d;
      grant_read_q           <= grant_read_d;
      busy_q                 <= busy_d;
      mem_read_valid_q       <= mem_read_valid_d;
      mem_read_address_q     <= mem_read_address_d;
      mem_write_valid_q      <= mem_write_valid_d;
      mem_write_address_q    <= mem_write_address_d;
      mem_write_data_q       <= mem_write_data_d;
      consumer_read_ready_q  <= consumer_read_ready_d;
      consumer_write_ready_q <= consumer_write_ready_d;
      consumer_read_data_q   <= consumer_read_data_d;
    end
  end

  assign consumer_read_ready  = consumer_read_ready_q;
  assign consumer_read_data   = consumer_read_data_q;
  assign consumer_write_ready = consumer_write_ready_q;
  assign mem_read_valid       = mem_read_valid_q;
  assign mem_read_address     = mem_read_address_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;
  assign busy                 = busy_q;
  assign grant_id             = grant_id_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb/tb_lsu_mem_arbiter.sv - self-checking bench for lsu_mem_arbiter
module tb_lsu_mem_arbiter;
  localparam int N   = 4;
  localparam int A   = 8;
  localparam int D   = 8;
  localparam int IDB = 2;

  logic             clk;
  logic             reset;
  logic [N-1:0]     consumer_read_valid;
  logic [N*A-1:0]   consumer_read_address;
  logic [N-1:0]     consumer_read_ready;
  logic [N*D-1:0]   consumer_read_data;
  logic [N-1:0]     consumer_write_valid;
  logic [N*A-1:0]   consumer_write_address;
  logic [N*D-1:0]   consumer_write_data;
  logic [N-1:0]     consumer_write_ready;
  logic             mem_read_valid;
  logic [A-1:0]     mem_read_address;
  logic             mem_read_ready;
  logic [D-1:0]     mem_read_data;
  logic             mem_write_valid;
  logic [A-1:0]     mem_write_address;
  logic [D-1:0]     mem_write_data;
  logic             mem_write_ready;
  logic             busy;
  logic [IDB-1:0]   grant_id;

  lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Requester-side model: what each LSU is asking for, plus expected state.
  bit             rv[N];
  bit             wv[N];
  logic [A-1:0]   raddr[N];
  logic [A-1:0]   waddr[N];
  logic [D-1:0]   wdata[N];
  logic [N*D-1:0] exp_rdata;
  int             model_rr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      consumer_read_valid[i]           = rv[i];
      consumer_write_valid[i]          = wv[i];
      consumer_read_address[i*A +: A]  = raddr[i];
      consumer_write_address[i*A +: A] = waddr[i];
      consumer_write_data[i*D +: D]    = wdata[i];
    end
  endtask

  // Fair scheduling: first requester at or after the pointer, wrapping.
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (model_rr + k) % N;
      if (rv[idx] || wv[idx]) return idx;
    end
    return -1;
  endfunction

  // One complete transaction: grant, wait cycles, memory completion,
  // release hold, then the LSU withdraws its request.
  task automatic do_txn(input int id, input bit is_read, input logic [D-1:0] rdata,
                        input int delay, input int hold);
    logic [A-1:0] ea;
    logic [D-1:0] ed;
    logic [N-1:0] one;
    bit           got;
    ea  = is_read ? raddr[id] : waddr[id];
    ed  = wdata[id];
    one = N'(1) << id;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      step();
      got = mem_read_valid | mem_write_valid;
    end
    check("grant_seen", got, 1);
    if (!got) return;
    check("grant_id", grant_id, id);
    check("grant_mem_rd_valid", mem_read_valid, is_read);
    check("grant_mem_wr_valid", mem_write_valid, !is_read);
    check("grant_busy", busy, 1);
    if (is_read) check("mem_rd_addr", mem_read_address, ea);
    else begin
      check("mem_wr_addr", mem_write_address, ea);
      check("mem_wr_data", mem_write_data, ed);
    end
    // Inputs change after the grant; the captured values must not follow.
    if (is_read) raddr[id] = ~ea;
    else begin
      waddr[id] = ~ea;
      wdata[id] = ~ed;
    end
    apply();
    mem_write_ready = is_read;
    mem_read_ready  = !is_read;
    for (int j = 0; j < delay; j++) begin
      step();
      check("wait_valid", is_read ? mem_read_valid : mem_write_valid, 1);
      check("wait_addr", is_read ? mem_read_address : mem_write_address, ea);
      if (!is_read) check("wait_wdata", mem_write_data, ed);
      check("wait_rd_ready", consumer_read_ready, 0);
      check("wait_wr_ready", consumer_write_ready, 0);
    end
    mem_read_ready  = is_read;
    mem_write_ready = !is_read;
    mem_read_data   = rdata;
    step();
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = D'($urandom);
    if (is_read) exp_rdata[id*D +: D] = rdata;
    check("done_mem_rd_valid", mem_read_valid, 0);
    check("done_mem_wr_valid", mem_write_valid, 0);
    check("done_rd_ready", consumer_read_ready, is_read ? one : '0);
    check("done_wr_ready", consumer_write_ready, is_read ? '0 : one);
    check("done_rd_data", consumer_read_data, exp_rdata);
    mem_read_ready  = 1'b1;
    mem_write_ready = 1'b1;
    for (int j = 0; j < hold; j++) begin
      step();
      check("hold_rd_ready", consumer_read_ready, is_read ? one : '0);
      check("hold_wr_ready", consumer_write_ready, is_read ? '0 : one);
      check("hold_mem_valid", {mem_read_valid, mem_write_valid}, 0);
      check("hold_busy", busy, 1);
    end
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    if (is_read) rv[id] = 1'b0;
    else         wv[id] = 1'b0;
    apply();
    step();
    check("rel_rd_ready", consumer_read_ready, 0);
    check("rel_wr_ready", consumer_write_ready, 0);
    check("rel_busy", busy, 0);
    check("rel_rd_data", consumer_read_data, exp_rdata);
    model_rr = (id + 1) % N;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_valid"}, mem_read_valid, 0);
    check({tag, "_rd_addr"}, mem_read_address, 0);
    check({tag, "_wr_valid"}, mem_write_valid, 0);
    check({tag, "_wr_addr"}, mem_write_address, 0);
    check({tag, "_wr_data"}, mem_write_data, 0);
    check({tag, "_rd_ready"}, consumer_read_ready, 0);
    check({tag, "_wr_ready"}, consumer_write_ready, 0);
    check({tag, "_rd_data"}, consumer_read_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant_id"}, grant_id, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    for (int i = 0; i < N; i++) begin
      rv[i] = 0; wv[i] = 0; raddr[i] = '0; waddr[i] = '0; wdata[i] = '0;
    end
    exp_rdata       = '0;
    model_rr        = 0;
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = '0;
    reset           = 1'b1;
    apply();
    step(); step(); step();
    check_all_zero("reset");
    reset = 1'b0;

    // Single read from consumer 2.
    rv[2] = 1; raddr[2] = 8'h1A; apply();
    do_txn(2, 1, 8'h5C, 3, 3);

    // Pointer now at 3: consumer 3 write beats consumer 0 read.
    wv[3] = 1; waddr[3] = 8'h3C; wdata[3] = 8'hC3;
    rv[0] = 1; raddr[0] = 8'h05; apply();
    do_txn(3, 0, 8'h00, 1, 0);
    do_txn(0, 1, 8'h9E, 2, 1);

    // Pointer should be 1: consumer 1 wins over consumer 0.
    wv[0] = 1; waddr[0] = 8'h10; wdata[0] = 8'h01;
    wv[1] = 1; waddr[1] = 8'h11; wdata[1] = 8'h02; apply();
    do_txn(1, 0, 8'h00, 0, 0);
    do_txn(0, 0, 8'h00, 1, 0);

    // Write forwarding: captured data survives input change.
    wv[1] = 1; waddr[1] = 8'h40; wdata[1] = 8'hA5; apply();
    do_txn(1, 0, 8'h00, 2, 1);

    // Slow release: consumer 0 holds its read; consumer 1 waits.
    rv[0] = 1; raddr[0] = 8'h33;
    wv[1] = 1; waddr[1] = 8'h44; wdata[1] = 8'h99; apply();
    do_txn(0, 1, 8'h6B, 1, 5);
    do_txn(1, 0, 8'h00, 1, 0);

    // Reset while waiting on a read.
    rv[2] = 1; raddr[2] = 8'h77; apply();
    step();
    check("rst_pre_valid", mem_read_valid, 1);
    reset = 1'b1;
    rv[2] = 0; apply();
    step();
    reset     = 1'b0;
    exp_rdata = '0;
    model_rr  = 0;
    check_all_zero("rst_mid");
    mem_read_ready = 1'b1;
    mem_read_data  = 8'hEE;
    step();
    mem_read_ready = 1'b0;
    check("late_rd_ready", consumer_read_ready, 0);
    check("late_busy", busy, 0);
    check("late_rd_data", consumer_read_data, 0);

    // Fairness from reset: all four read together.
    for (int i = 0; i < N; i++) begin
      rv[i] = 1; raddr[i] = A'(8'h80 + i);
    end
    apply();
    for (int i = 0; i < N; i++) do_txn(i, 1, D'(8'hD0 + i), 1, 0);

    // Randomized traffic against the scheduling model.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && ($urandom % 3 == 0)) begin rv[i] = 1; raddr[i] = A'($urandom); end
        if (!wv[i] && ($urandom % 3 == 0)) begin
          wv[i] = 1; waddr[i] = A'($urandom); wdata[i] = D'($urandom);
        end
      end
      if (pick() < 0) begin
        id = int'($urandom % N);
        rv[id] = 1; raddr[id] = A'($urandom);
      end
      apply();
      id = pick();
      do_txn(id, rv[id], D'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
